// File: rtl/ce_seq_pkg.sv
// ============================================================================
// Module  : ce_seq_pkg
// Brief   : Shared types and sizing helpers for the clock-enable sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ce_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_HOLD = 2'd3
  } ce_state_e;

  // Timer must reach the last channel's fall point without wrapping.
  function automatic int ce_seq_tw(input int gap, input int nch,
                                   input int stagger, input int len);
    return $clog2(gap + (nch - 1) * stagger + len + 2);
  endfunction

  // Rise offset of channel idx, measured from the release edge.
  function automatic int ce_seq_start(input int gap, input int stagger,
                                      input int idx);
    return gap + idx * stagger;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ce_window_gen.sv
// ============================================================================
// Module  : ce_window_gen
// Brief   : One clock-enable channel: registered timer-window comparator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ce_window_gen #(
  parameter int TW    = 2,
  parameter int START = 0,
  parameter int LEN   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [TW-1:0] t,
  input  logic          run,
  input  logic          clear,
  output logic          ce
);

  logic w_hit;

  // LEN of zero turns the window into a level that holds once reached.
  assign w_hit = (int'(t) >= START) && ((LEN == 0) || (int'(t) < START + LEN));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       ce <= 1'b0;
    else if (clear) ce <= 1'b0;
    else if (run)   ce <= w_hit;
  end

endmodule

`default_nettype wire

// File: rtl/ce_release_sequencer.sv
// ============================================================================
// Module  : ce_release_sequencer
// Brief   : Qualifies a held soft-reset request, then emits staggered CE windows.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ce_release_sequencer
  import ce_seq_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int HOLD_CYC = 2,
  parameter int GAP      = 1,
  parameter int STAGGER  = 0,
  parameter int CE_LEN   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sreq,
  output logic [NCH-1:0] ce,
  output logic           busy,
  output logic           done,
  output logic           short_err,
  output logic           abort
);

  localparam int c_tw  = ce_seq_tw(GAP, NCH, STAGGER, CE_LEN);
  localparam int c_hw  = $clog2(HOLD_CYC + 1);
  localparam int c_end = ce_seq_start(GAP, STAGGER, NCH - 1) + CE_LEN;
  localparam logic [c_tw-1:0] c_end_t = c_tw'(c_end);
  localparam logic [c_hw-1:0] c_hold  = c_hw'(HOLD_CYC);

  ce_state_e       r_state, w_state_nxt;
  logic [c_hw-1:0] r_hold, w_hold_nxt;
  logic [c_tw-1:0] r_t, w_t_nxt;
  logic            r_busy, r_done, r_serr, r_abort;
  logic            w_busy_nxt, w_done_nxt, w_serr_nxt, w_abort_nxt;
  logic            w_ld, w_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_hold  <= '0;
      r_t     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_serr  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_t     <= w_t_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_serr  <= w_serr_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  // w_ld marks edges where the channels sample the timer; w_clr drops them all.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_t_nxt     = r_t;
    w_ld        = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (sreq) begin
          w_state_nxt = ST_ARM;
          w_hold_nxt  = c_hw'(1);
          w_clr       = 1'b1;
        end
      end
      ST_ARM: begin
        if (sreq) begin
          if (r_hold != c_hold) w_hold_nxt = r_hold + c_hw'(1);
        end else if (r_hold != c_hold) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RUN;
          w_t_nxt     = '0;
          w_ld        = 1'b1;
        end
      end
      ST_RUN: begin
        if (sreq) begin
          w_state_nxt = ST_ARM;
          w_hold_nxt  = c_hw'(1);
          w_clr       = 1'b1;
        end else begin
          w_t_nxt = r_t + c_tw'(1);
          w_ld    = 1'b1;
        end
      end
      ST_HOLD: begin
        if (sreq) begin
          w_state_nxt = ST_ARM;
          w_hold_nxt  = c_hw'(1);
          w_clr       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_ld && (w_t_nxt == c_end_t))
      w_state_nxt = (CE_LEN == 0) ? ST_HOLD : ST_IDLE;
  end

  always_comb begin
    w_busy_nxt  = (w_state_nxt == ST_ARM) || (w_state_nxt == ST_RUN);
    w_done_nxt  = w_ld && (w_t_nxt == c_end_t);
    w_serr_nxt  = (r_state == ST_ARM) && !sreq && (r_hold != c_hold);
    w_abort_nxt = (r_state == ST_RUN) && sreq;
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      ce_window_gen #(
        .TW    (c_tw),
        .START (ce_seq_start(GAP, STAGGER, i)),
        .LEN   (CE_LEN)
      ) u_win (
        .clk   (clk),
        .rst   (rst),
        .t     (w_t_nxt),
        .run   (w_ld),
        .clear (w_clr),
        .ce    (ce[i])
      );
    end
  endgenerate

  assign busy      = r_busy;
  assign done      = r_done;
  assign short_err = r_serr;
  assign abort     = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_ce_release_sequencer.sv
// ============================================================================
// Module  : tb_ce_release_sequencer
// Brief   : Vector-table and scoreboard bench over three sequencer configurations.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ce_release_sequencer;

  typedef struct packed {
    logic [1:0] sel;
    logic       sreq;
    logic [3:0] ce;
    logic       busy;
    logic       done;
    logic       serr;
    logic       abrt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sreq = 1'b0;
  logic [1:0] sel = 2'd0;

  logic       sreq_a, sreq_b, sreq_c;
  logic [1:0] ce_a, ce_c;
  logic [3:0] ce_b;
  logic       busy_a, done_a, serr_a, abrt_a;
  logic       busy_b, done_b, serr_b, abrt_b;
  logic       busy_c, done_c, serr_c, abrt_c;
  logic [7:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t       vecs[$];
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  assign sreq_a = (sel == 2'd0) ? sreq : 1'b0;
  assign sreq_b = (sel == 2'd1) ? sreq : 1'b0;
  assign sreq_c = (sel == 2'd2) ? sreq : 1'b0;

  always_comb begin
    obs = '0;
    case (sel)
      2'd0:    obs = {2'b00, ce_a, busy_a, done_a, serr_a, abrt_a};
      2'd1:    obs = {ce_b, busy_b, done_b, serr_b, abrt_b};
      default: obs = {2'b00, ce_c, busy_c, done_c, serr_c, abrt_c};
    endcase
  end

  // A: nominal staggered pulses; B: all channels together, GAP=0; C: level mode.
  ce_release_sequencer #(.NCH(2), .HOLD_CYC(2), .GAP(1), .STAGGER(1), .CE_LEN(2)) u_dut_a (
    .clk(clk), .rst(rst), .sreq(sreq_a), .ce(ce_a),
    .busy(busy_a), .done(done_a), .short_err(serr_a), .abort(abrt_a));

  ce_release_sequencer #(.NCH(4), .HOLD_CYC(2), .GAP(0), .STAGGER(0), .CE_LEN(2)) u_dut_b (
    .clk(clk), .rst(rst), .sreq(sreq_b), .ce(ce_b),
    .busy(busy_b), .done(done_b), .short_err(serr_b), .abort(abrt_b));

  ce_release_sequencer #(.NCH(2), .HOLD_CYC(2), .GAP(1), .STAGGER(2), .CE_LEN(0)) u_dut_c (
    .clk(clk), .rst(rst), .sreq(sreq_c), .ce(ce_c),
    .busy(busy_c), .done(done_c), .short_err(serr_c), .abort(abrt_c));

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got ce=%h busy=%b done=%b short_err=%b abort=%b, expected ce=%h busy=%b done=%b short_err=%b abort=%b",
               name, got[7:4], got[3], got[2], got[1], got[0],
               exp[7:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive at the falling edge, compare 1 ns after the following rising edge.
  task automatic step(input logic [1:0] s, input logic r, input logic rq,
                      input logic [3:0] e_ce, input logic e_b, input logic e_d,
                      input logic e_s, input logic e_a, input string name);
    logic [7:0] exp;
    @(negedge clk);
    sel  = s;
    rst  = r;
    sreq = rq;
    sb.push_back({e_ce, e_b, e_d, e_s, e_a});
    @(posedge clk);
    #1;
    exp = sb.pop_front();
    check(name, obs, exp);
  endtask

  function automatic void add(input logic [1:0] s, input logic rq, input logic [3:0] e_ce,
                              input logic e_b, input logic e_d, input logic e_s, input logic e_a);
    vec_t v;
    v.sel = s; v.sreq = rq; v.ce = e_ce;
    v.busy = e_b; v.done = e_d; v.serr = e_s; v.abrt = e_a;
    vecs.push_back(v);
  endfunction

  initial begin
    // A nominal: T=3, ce[0] edges 4..5, ce[1] edges 5..6, done at 7
    add(0,1,4'h0,1,0,0,0); add(0,1,4'h0,1,0,0,0); add(0,0,4'h0,1,0,0,0);
    add(0,0,4'h1,1,0,0,0); add(0,0,4'h3,1,0,0,0); add(0,0,4'h2,1,0,0,0);
    add(0,0,4'h0,0,1,0,0); add(0,0,4'h0,0,0,0,0);
    // A short request
    add(0,1,4'h0,1,0,0,0); add(0,0,4'h0,0,0,1,0); add(0,0,4'h0,0,0,0,0);
    // A abort at edge 5, re-release at edge 7
    add(0,1,4'h0,1,0,0,0); add(0,1,4'h0,1,0,0,0); add(0,0,4'h0,1,0,0,0);
    add(0,0,4'h1,1,0,0,0); add(0,1,4'h0,1,0,0,1); add(0,1,4'h0,1,0,0,0);
    add(0,0,4'h0,1,0,0,0); add(0,0,4'h1,1,0,0,0); add(0,0,4'h3,1,0,0,0);
    add(0,0,4'h2,1,0,0,0); add(0,0,4'h0,0,1,0,0); add(0,0,4'h0,0,0,0,0);
    // B: hold 3 (saturating count), T=4, all channels edges 4..5
    add(1,1,4'h0,1,0,0,0); add(1,1,4'h0,1,0,0,0); add(1,1,4'h0,1,0,0,0);
    add(1,0,4'hF,1,0,0,0); add(1,0,4'hF,1,0,0,0); add(1,0,4'h0,0,1,0,0);
    add(1,0,4'h0,0,0,0,0);
    // C level mode: T=3, ce[0] from 4, ce[1] from 6 with done, re-request at 10
    add(2,1,4'h0,1,0,0,0); add(2,1,4'h0,1,0,0,0); add(2,0,4'h0,1,0,0,0);
    add(2,0,4'h1,1,0,0,0); add(2,0,4'h1,1,0,0,0); add(2,0,4'h3,0,1,0,0);
    add(2,0,4'h3,0,0,0,0); add(2,0,4'h3,0,0,0,0); add(2,0,4'h3,0,0,0,0);
    add(2,1,4'h0,1,0,0,0); add(2,0,4'h0,0,0,1,0); add(2,0,4'h0,0,0,0,0);

    step(0, 1'b0, 1'b0, 4'h0, 0,0,0,0, "reset_a");
    step(1, 1'b0, 1'b1, 4'h0, 0,0,0,0, "reset_b");
    step(2, 1'b0, 1'b1, 4'h0, 0,0,0,0, "reset_c");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].sel, 1'b1, vecs[i].sreq, vecs[i].ce, vecs[i].busy,
           vecs[i].done, vecs[i].serr, vecs[i].abrt, $sformatf("vec%0d", i));

    // Asynchronous reset while channels are active
    step(0, 1'b1, 1'b1, 4'h0, 1,0,0,0, "arst_e1");
    step(0, 1'b1, 1'b1, 4'h0, 1,0,0,0, "arst_e2");
    step(0, 1'b1, 1'b0, 4'h0, 1,0,0,0, "arst_e3");
    step(0, 1'b1, 1'b0, 4'h1, 1,0,0,0, "arst_e4");
    step(0, 1'b1, 1'b0, 4'h3, 1,0,0,0, "arst_e5");
    #2;
    rst = 1'b0;
    sb.push_back(8'h00);
    #1;
    check("arst_immediate", obs, sb.pop_front());
    step(0, 1'b0, 1'b0, 4'h0, 0,0,0,0, "arst_held");
    step(0, 1'b1, 1'b0, 4'h0, 0,0,0,0, "arst_idle1");
    step(0, 1'b1, 1'b0, 4'h0, 0,0,0,0, "arst_idle2");

    // Request already high when reset releases counts as a fresh one-sample hold
    step(0, 1'b0, 1'b1, 4'h0, 0,0,0,0, "rel_in_reset");
    step(0, 1'b1, 1'b1, 4'h0, 1,0,0,0, "rel_first_edge");
    step(0, 1'b1, 1'b0, 4'h0, 0,0,1,0, "rel_short");
    step(0, 1'b1, 1'b0, 4'h0, 0,0,0,0, "rel_idle");

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
